lsu_mem_if: RTL and testbench

- Load/store unit between the RV32I execute stage and the data memory (`mem_data`).
- Takes one load/store request at a time from the core and checks alignment.
- Drives a word-addressed memory port with byte enables, then returns the load result (aligned, sign- or zero-extended) or a store-completion pulse.
- This is the block the core's load and store directed tests exercise end to end.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_load_extract.sv | 31 +++
 rtl/lsu_mem_if.sv | 125 ++++++++++++
 tb/tb_lsu_mem_if.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I load/store funct3 codes
//   - FSM state encoding
//   - byte-enable type
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, MREQ, RESP} state_t;

  typedef logic [3:0] be_t;

  // Legal funct3 for the direction, and naturally aligned for its size.
  function automatic logic access_ok(input logic store, input logic [2:0] f3,
                                     input logic [1:0] off);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = !off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = !store;
      F3_HU:   ok = !store && !off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// lsu_load_extract: picks the addressed byte/half out of a memory word and
// sign- or zero-extends it according to the load funct3.
//   word    in  32  raw memory word
//   funct3  in  3   load funct3
//   off     in  2   byte offset addr[1:0]
//   result  out 32  extended load value (LW passes the word through)
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    result = {{24{b[7]}}, b};
      F3_BU:   result = {24'b0, b};
      F3_H:    result = {{16{h[15]}}, h};
      F3_HU:   result = {16'b0, h};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: RV32I load/store unit between execute and data memory.
// One request at a time: IDLE accepts, MREQ holds a word-addressed memory
// request until mem_ack, RESP emits a one-cycle rsp_valid pulse.
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/ready/store/funct3/addr/wdata   core request
//   rsp_valid/rdata/err          completion pulse, load data, error flag
//   mem_req/we/be/addr/wdata     memory request (held stable until ack)
//   mem_ack/rdata                memory completion, read word
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int AW     = 32,
  parameter int MEM_AW = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [AW-1:0]     req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  state_t     state;
  logic       st_store;
  logic [2:0] st_f3;
  logic [1:0] st_off;
  logic [31:0] ld_data;

  function automatic be_t store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    return be_t'(4'b0001 << off);
      F3_H:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store data into every lane it may land in, so the memory
  // only needs the byte enables to pick the right bytes.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      F3_B:    return {4{wd[7:0]}};
      F3_H:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  lsu_load_extract u_extract (
    .word   (mem_rdata),
    .funct3 (st_f3),
    .off    (st_off),
    .result (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      st_store  <= 1'b0;
      st_f3     <= '0;
      st_off    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            st_store  <= req_store;
            st_f3     <= req_funct3;
            st_off    <= req_addr[1:0];
            req_ready <= 1'b0;
            if (access_ok(req_store, req_funct3, req_addr[1:0])) begin
              state     <= MREQ;
              mem_req   <= 1'b1;
              mem_we    <= req_store;
              mem_addr  <= MEM_AW'(req_addr[AW-1:2]);
              mem_be    <= req_store ? store_be(req_funct3, req_addr[1:0]) : 4'b1111;
              mem_wdata <= req_store ? store_lanes(req_funct3, req_wdata) : '0;
            end else begin
              // Rejected without touching memory.
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        MREQ: begin
          if (mem_ack) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_be    <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= st_store ? 32'h0 : ld_data;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: directed + randomized bench for lsu_mem_if. A byte-level
// reference memory predicts every response; a separate word memory with
// random ack latency serves the DUT. One compare process checks handshake,
// memory-port and response outputs every cycle.
module tb_lsu_mem_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata = '0;

  lsu_mem_if dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  refb [0:63];
  logic [31:0] memw [0:15];

  bit          exp_legal, exp_we;
  logic [3:0]  exp_be;
  logic [31:0] exp_wdata, exp_waddr, exp_rdata;

  task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    int sz;
    longint v;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    exp_legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 ||
                 ((f3 == 3'd4 || f3 == 3'd5) && !st)) && (a % sz == 0);
    exp_we    = st;
    exp_waddr = a >> 2;
    exp_rdata = 0;
    exp_be    = 4'hF;
    exp_wdata = 0;
    if (exp_legal && st) begin
      exp_be    = 4'(((1 << sz) - 1) << (a % 4));
      exp_wdata = (sz == 1) ? wd[7:0] * 32'h0101_0101 :
                  (sz == 2) ? wd[15:0] * 32'h0001_0001 : wd;
      for (int i = 0; i < sz; i++) refb[a + i] = wd[8*i +: 8];
    end else if (exp_legal) begin
      v = 0;
      for (int i = 0; i < sz; i++) v = v | (longint'(refb[a + i]) << (8 * i));
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v - (longint'(1) << (8 * sz));
      exp_rdata = v[31:0];
    end
  endtask

  // ---------------- memory responder ----------------
  int   ack_delay = 0, cnt = 0;
  bit   force_ack = 0, acked = 0;
  int   ack_cyc = 0;
  logic [3:0]  ack_be;
  logic [31:0] ack_wdata;

  always @(negedge clk) begin
    if (force_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = $urandom;
    end else if (mem_req) begin
      if (cnt == ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = memw[mem_addr[3:0]];
        if (mem_we)
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) memw[mem_addr[3:0]][8*b +: 8] = mem_wdata[8*b +: 8];
        acked = 1; ack_cyc = cyc; ack_be = mem_be; ack_wdata = mem_wdata;
        cnt = 0;
      end else begin
        mem_ack = 1'b0;
        cnt++;
      end
    end else begin
      mem_ack   = 1'b0;
      cnt       = 0;
      mem_rdata = $urandom;
    end
  end

  // ---------------- compare process ----------------
  bit   chk_en = 0, have_exp = 0, exp_rv, exp_mreq;
  int   acc_cyc = 0, rsp_cyc = 0;
  logic [31:0] last_rdata;
  logic        last_err;

  always @(negedge clk) begin
    if (chk_en) begin
      exp_rv   = have_exp && (exp_legal ? (acked && cyc == ack_cyc + 1) : cyc == acc_cyc);
      exp_mreq = have_exp && exp_legal && (!acked || cyc == ack_cyc);
      chk("req_ready", req_ready, !have_exp);
      chk("rsp_valid", rsp_valid, exp_rv);
      chk("mem_req", mem_req, exp_mreq);
      if (exp_mreq) begin
        chk("mem_addr", mem_addr, exp_waddr[29:0]);
        chk("mem_we", mem_we, exp_we);
        chk("mem_be", mem_be, exp_be);
        if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
      end
      if (exp_rv) begin
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", rsp_err, !exp_legal);
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
        rsp_cyc    = cyc;
        have_exp   = 0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int dly);
    int t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("ready_timeout", 32'd1, 32'd0);
    ack_delay  = dly;
    req_valid  = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    model(st, f3, a, wd);
    @(posedge clk); #1;
    req_valid = 1'b0;
    acc_cyc = cyc; acked = 0; have_exp = 1;
    t = 0;
    while (have_exp && t < 100) begin @(negedge clk); t++; end
    if (have_exp) begin
      chk("rsp_timeout", 32'd1, 32'd0);
      have_exp = 0;
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      memw[i] = (i == 0) ? 32'h8765_43A1 : $urandom;
      for (int b = 0; b < 4; b++) refb[4*i + b] = memw[i][8*b +: 8];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    chk_en = 1;

    // Loads of word0 with literal expectations.
    do_req(0, 3'b010, 32'h0, 32'h0, 0);
    chk("lw0_data", last_rdata, 32'h8765_43A1);
    chk("lw0_err", last_err, 0);
    chk("lw0_latency", rsp_cyc - acc_cyc, 1);
    do_req(0, 3'b000, 32'h0, 32'h0, 1);
    chk("lb0", last_rdata, 32'hFFFF_FFA1);
    do_req(0, 3'b100, 32'h0, 32'h0, 0);
    chk("lbu0", last_rdata, 32'h0000_00A1);
    do_req(0, 3'b001, 32'h2, 32'h0, 2);
    chk("lh2", last_rdata, 32'hFFFF_8765);
    do_req(0, 3'b101, 32'h2, 32'h0, 0);
    chk("lhu2", last_rdata, 32'h0000_8765);

    // Stores and readback.
    do_req(1, 3'b000, 32'h5, 32'h0000_00CC, 0);
    chk("sb5_be", ack_be, 4'b0010);
    chk("sb5_wdata", ack_wdata, 32'hCCCC_CCCC);
    chk("sb5_rdata", last_rdata, 0);
    do_req(0, 3'b010, 32'h4, 32'h0, 0);
    chk("sb5_readback", (last_rdata >> 8) & 32'hFF, 32'hCC);
    do_req(1, 3'b001, 32'h6, 32'h0000_1234, 1);
    chk("sh6_be", ack_be, 4'b1100);
    chk("sh6_wdata", ack_wdata, 32'h1234_1234);
    do_req(0, 3'b010, 32'h4, 32'h0, 0);
    chk("sh6_readback", last_rdata >> 16, 32'h1234);

    // Misaligned / illegal.
    do_req(0, 3'b010, 32'h2, 32'h0, 0);
    chk("lw2_err", last_err, 1);
    chk("lw2_rdata", last_rdata, 0);
    chk("lw2_latency", rsp_cyc - acc_cyc, 0);
    do_req(1, 3'b001, 32'h1, 32'hFFFF, 0);
    chk("sh1_err", last_err, 1);
    do_req(1, 3'b100, 32'h8, 32'h55, 0);
    chk("sbu_err", last_err, 1);

    // Slow memory: port held stable, single response.
    do_req(1, 3'b010, 32'hC, 32'hDEAD_BEEF, 5);
    chk("slow_latency", rsp_cyc - acc_cyc, 6);

    // Reset while waiting in MREQ, then a stray ack.
    @(negedge clk);
    ack_delay = 1000;
    req_valid = 1'b1; req_store = 0; req_funct3 = 3'b010; req_addr = 32'h0;
    model(0, 3'b010, 32'h0, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0; acc_cyc = cyc; acked = 0; have_exp = 1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    chk_en = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; have_exp = 0; force_ack = 1;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    force_ack = 0; chk_en = 1;
    repeat (3) @(negedge clk);
    do_req(0, 3'b010, 32'h0, 32'h0, 0);
    chk("post_rst_lw", last_rdata, 32'h8765_43A1);

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      bit          st;
      logic [2:0]  f3;
      logic [31:0] a;
      st = 1'($urandom % 2);
      f3 = 3'($urandom % 8);
      a  = $urandom % 64;
      if ($urandom % 3 != 0) a = (f3[1:0] == 2'd0) ? a : (f3[1:0] == 2'd1) ? (a & ~32'h1) : (a & ~32'h3);
      do_req(st, f3, a, $urandom, int'($urandom % 4));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
